// File: rtl/temp_meas_pkg.sv
// Shared types and defaults for the temperature measurement sequencer.
package temp_meas_pkg;

    localparam int WIDTH_DEF    = 10;
    localparam int AVG_LOG2_DEF = 2;
    localparam int PERIOD_W_DEF = 16;
    localparam int TIMEOUT_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQ       = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        UPDATE    = 3'd5
    } temp_meas_state_t;

    // Accumulator holds 2^avg_log2 full-scale samples without overflow.
    function automatic int acc_w(input int width, input int avg_log2);
        return width + avg_log2;
    endfunction

endpackage

// File: rtl/temp_meas_avg.sv
// Sample accumulator, averaging shift and hysteretic over-temperature alarm.
module temp_meas_avg
    import temp_meas_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic             lfClk,
    input  logic             rst_n,
    input  logic             add,
    input  logic             update,
    input  logic             clr,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] thrHi,
    input  logic [WIDTH-1:0] thrLo,
    output logic             full,
    output logic [WIDTH-1:0] avg,
    output logic             avgValid,
    output logic             alarm
);

    localparam int ACC_W = acc_w(WIDTH, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] avg_r;
    logic             avg_valid_r;
    logic             alarm_r;
    logic [WIDTH-1:0] avg_next_s;

    // "full" means the next add completes the averaging window.
    assign full       = (cnt_r == CNT_LAST);
    assign avg_next_s = acc_r[ACC_W-1:AVG_LOG2];
    assign avg        = avg_r;
    assign avgValid   = avg_valid_r;
    assign alarm      = alarm_r;

    // Accumulate samples, publish average and update alarm hysteresis.
    always_ff @(posedge lfClk) begin
        if (!rst_n) begin
            acc_r       <= ACC_W'(0);
            cnt_r       <= CNT_W'(0);
            avg_r       <= WIDTH'(0);
            avg_valid_r <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            avg_valid_r <= 1'b0;
            if (clr) begin
                acc_r <= ACC_W'(0);
                cnt_r <= CNT_W'(0);
            end else if (update) begin
                avg_r       <= avg_next_s;
                avg_valid_r <= 1'b1;
                acc_r       <= ACC_W'(0);
                cnt_r       <= CNT_W'(0);
                if (avg_next_s > thrHi) begin
                    alarm_r <= 1'b1;
                end else if (avg_next_s < thrLo) begin
                    alarm_r <= 1'b0;
                end else begin
                    alarm_r <= alarm_r;
                end
            end else if (add) begin
                acc_r <= acc_r + ACC_W'(sample);
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/temp_meas_sequencer.sv
// Periodic measurement initiator: handshake FSM, interval/timeout counters, averaging.
module temp_meas_sequencer
    import temp_meas_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                lfClk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH-1:0]    thrHi,
    input  logic [WIDTH-1:0]    thrLo,
    input  logic                errClr,
    output logic                measStart,
    input  logic                measDone,
    input  logic [WIDTH-1:0]    measCycles,
    output logic [WIDTH-1:0]    avg,
    output logic                avgValid,
    output logic                alarm,
    output logic                err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    temp_meas_state_t    state_r, state_next_s;
    logic [PERIOD_W-1:0] tick_r, tick_next_s;
    logic [TMO_W-1:0]    tmo_r, tmo_next_s;
    logic                abort_r, abort_next_s;
    logic                meas_start_r, err_r;
    logic                start_s, add_s, upd_s, clr_s, err_set_s, full_s;

    assign measStart = meas_start_r;
    assign err       = err_r;

    // Next-state logic; UPDATE doubles as the first interval tick so the
    // sample spacing stays period + 7 whether or not an average is published.
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        tmo_next_s   = tmo_r;
        abort_next_s = abort_r;
        start_s      = 1'b0;
        add_s        = 1'b0;
        upd_s        = 1'b0;
        clr_s        = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                clr_s        = 1'b1;
                abort_next_s = 1'b0;
                if (enable) begin
                    state_next_s = WAIT_TICK;
                    tick_next_s  = period;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_TICK, UPDATE: begin
                upd_s = (state_r == UPDATE);
                if (!enable) begin
                    state_next_s = IDLE;
                end else if (tick_r == PERIOD_W'(0)) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = WAIT_TICK;
                    tick_next_s  = tick_r - PERIOD_W'(1);
                end
            end
            REQ: begin
                if (!enable) begin
                    state_next_s = IDLE;
                end else begin
                    start_s      = 1'b1;
                    state_next_s = WAIT_BUSY;
                    tmo_next_s   = TMO_W'(0);
                end
            end
            WAIT_BUSY, WAIT_DONE: begin
                abort_next_s = abort_r | ~enable;
                if ((state_r == WAIT_BUSY) && !measDone) begin
                    state_next_s = WAIT_DONE;
                    tmo_next_s   = TMO_W'(0);
                end else if ((state_r == WAIT_DONE) && measDone) begin
                    if (abort_r || !enable) begin
                        state_next_s = IDLE;
                    end else begin
                        add_s        = 1'b1;
                        tick_next_s  = period;
                        state_next_s = full_s ? UPDATE : WAIT_TICK;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    err_set_s    = 1'b1;
                    tick_next_s  = period;
                    state_next_s = (abort_r || !enable) ? IDLE : WAIT_TICK;
                end else begin
                    tmo_next_s = tmo_r + TMO_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters and registered handshake/error outputs.
    always_ff @(posedge lfClk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            tick_r       <= PERIOD_W'(0);
            tmo_r        <= TMO_W'(0);
            abort_r      <= 1'b0;
            meas_start_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            tick_r       <= tick_next_s;
            tmo_r        <= tmo_next_s;
            abort_r      <= abort_next_s;
            meas_start_r <= start_s;
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (errClr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    temp_meas_avg #(
        .WIDTH    (WIDTH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .lfClk    (lfClk),
        .rst_n    (rst_n),
        .add      (add_s),
        .update   (upd_s),
        .clr      (clr_s),
        .sample   (measCycles),
        .thrHi    (thrHi),
        .thrLo    (thrLo),
        .full     (full_s),
        .avg      (avg),
        .avgValid (avgValid),
        .alarm    (alarm)
    );

endmodule

// File: tb/tb_temp_meas_sequencer.sv
// Directed bench with a transaction-level timing/averaging model and responder.
module tb_temp_meas_sequencer;

    logic        lfClk = 1'b0;
    logic        rst_n, enable, errClr, measDone, enable0, measDone0;
    logic [15:0] period, period0;
    logic [9:0]  thrHi, thrLo, measCycles, measCycles0;
    logic        measStart, avgValid, alarm, err;
    logic        measStart0, avgValid0, alarm0, err0;
    logic [9:0]  avg, avg0;

    always #5 lfClk = ~lfClk;

    temp_meas_sequencer #(.WIDTH(10), .AVG_LOG2(2), .PERIOD_W(16), .TIMEOUT(8)) dut (
        .lfClk(lfClk), .rst_n(rst_n), .enable(enable), .period(period),
        .thrHi(thrHi), .thrLo(thrLo), .errClr(errClr), .measStart(measStart),
        .measDone(measDone), .measCycles(measCycles), .avg(avg),
        .avgValid(avgValid), .alarm(alarm), .err(err));

    temp_meas_sequencer #(.WIDTH(10), .AVG_LOG2(0), .PERIOD_W(16), .TIMEOUT(8)) dut0 (
        .lfClk(lfClk), .rst_n(rst_n), .enable(enable0), .period(period0),
        .thrHi(thrHi), .thrLo(thrLo), .errClr(errClr), .measStart(measStart0),
        .measDone(measDone0), .measCycles(measCycles0), .avg(avg0),
        .avgValid(avgValid0), .alarm(alarm0), .err(err0));

    int checks = 0, errors = 0;
    int cyc = 0, exp_start = -1, av_cyc = -1, err_cyc = -1;
    int sum = 0, n = 0, rc = 0, rc0 = 0, last_start = 0, start_gap = 0, st_cnt = 0;
    logic [9:0] av_val, m_avg = 10'd0;
    bit m_alarm = 1'b0, m_err = 1'b0, m_av = 1'b0;
    bit discard = 1'b0, busy = 1'b0, resp_on = 1'b1, chk_on = 1'b0;
    logic [9:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Model update, per-cycle compare and measurement-block responders.
    initial forever begin
        @(posedge lfClk);
        cyc++;
        m_av = 1'b0;
        if (cyc == av_cyc) begin
            m_avg = av_val;
            m_av  = 1'b1;
            if (av_val > thrHi) m_alarm = 1'b1;
            else if (av_val < thrLo) m_alarm = 1'b0;
        end
        if (cyc == err_cyc) m_err = 1'b1;
        #1;
        if (chk_on) begin
            chk("measStart", measStart, (cyc == exp_start));
            chk("avgValid", avgValid, m_av);
            chk("avg", avg, m_avg);
            chk("alarm", alarm, m_alarm);
            chk("err", err, m_err);
        end
        if (rc > 0) begin
            rc++;
            if (rc == 2) measDone = 1'b0;
            else if (rc == 5) begin
                measCycles = (q.size() > 0) ? q.pop_front() : 10'd0;
                measDone = 1'b1;
                rc = 0;
                busy = 1'b0;
                if (!discard && enable) begin
                    sum += measCycles;
                    n++;
                    exp_start = cyc + period + 3;
                    if (n == 4) begin
                        av_cyc = cyc + 2;
                        av_val = 10'(sum / 4);
                        sum = 0;
                        n = 0;
                    end
                end
                discard = 1'b0;
            end
        end
        if (measStart === 1'b1) begin
            st_cnt++;
            start_gap = cyc - last_start;
            last_start = cyc;
            busy = resp_on;
            if (resp_on) rc = 1;
            else begin
                err_cyc = cyc + 8;
                exp_start = cyc + period + 10;
            end
        end
        if (rc0 > 0) begin
            rc0++;
            if (rc0 == 2) measDone0 = 1'b0;
            else if (rc0 == 5) begin
                measDone0 = 1'b1;
                rc0 = 0;
            end
        end
        if (measStart0 === 1'b1) rc0 = 1;
    end

    task automatic do_enable();
        @(posedge lfClk); #2;
        enable = 1'b1;
        exp_start = cyc + period + 3;
    endtask

    task automatic wait_start();
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge lfClk); #2;
            if (measStart) got = 1'b1;
        end
        if (!got) chk("wait_measStart_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_av();
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge lfClk); #2;
            if (avgValid) got = 1'b1;
        end
        if (!got) chk("wait_avgValid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st0, pulses, last0;
        bit got_err;
        rst_n = 1'b0; enable = 1'b0; errClr = 1'b0; measDone = 1'b1;
        period = 16'd3; period0 = 16'd0; thrHi = 10'd800; thrLo = 10'd700;
        measCycles = 10'd0; measCycles0 = 10'd1023; enable0 = 1'b0; measDone0 = 1'b1;
        @(posedge lfClk);
        chk_on = 1'b1;
        @(posedge lfClk); #2;
        chk("rst_avg", avg, 32'd0);
        chk("rst_measStart", measStart, 32'd0);
        chk("rst_err", err, 32'd0);
        rst_n = 1'b1;

        // Averaging with truncation and measStart spacing of period + 7.
        q = '{10'd100, 10'd101, 10'd102, 10'd103};
        do_enable();
        wait_av();
        chk("avg_101", avg, 32'd101);
        chk("alarm_low", alarm, 32'd0);
        chk("start_gap_10", start_gap, 32'd10);

        // Alarm hysteresis: set, hold inside band, clear.
        repeat (4) q.push_back(10'd900);
        wait_av();
        chk("avg_900", avg, 32'd900);
        chk("alarm_set", alarm, 32'd1);
        repeat (4) q.push_back(10'd750);
        wait_av();
        chk("alarm_hold", alarm, 32'd1);
        repeat (4) q.push_back(10'd600);
        wait_av();
        chk("alarm_clr", alarm, 32'd0);

        // Responder never goes busy: timeout sets err, next request still issued.
        resp_on = 1'b0;
        got_err = 1'b0;
        for (int k = 0; k < 40 && !got_err; k++) begin
            @(posedge lfClk); #2;
            if (err) got_err = 1'b1;
        end
        chk("err_set", err, 32'd1);
        resp_on = 1'b1;
        @(posedge lfClk); #2;
        errClr = 1'b1;
        @(posedge lfClk);
        m_err = 1'b0;
        #2;
        errClr = 1'b0;
        chk("err_clr", err, 32'd0);
        repeat (4) q.push_back(10'd200);
        wait_av();
        chk("avg_200", avg, 32'd200);

        // Drop enable while WAIT_DONE: sample discarded, no further requests.
        q.push_back(10'd1000);
        wait_start();
        repeat (3) @(posedge lfClk);
        #2;
        enable = 1'b0;
        discard = busy;
        exp_start = -1;
        sum = 0; n = 0;
        st0 = st_cnt;
        repeat (30) @(posedge lfClk);
        #2;
        chk("no_start_after_disable", st_cnt - st0, 32'd0);
        repeat (4) q.push_back(10'd300);
        do_enable();
        wait_av();
        chk("avg_300", avg, 32'd300);

        // One-cycle reset inside WAIT_BUSY, then a fresh four-sample round.
        q.push_back(10'd999);
        q.push_back(10'd50); q.push_back(10'd50); q.push_back(10'd50); q.push_back(10'd52);
        wait_start();
        @(posedge lfClk); #2;
        rst_n = 1'b0;
        @(posedge lfClk);
        m_avg = 10'd0; m_alarm = 1'b0; m_err = 1'b0; m_av = 1'b0;
        av_cyc = -1; err_cyc = -1; sum = 0; n = 0;
        discard = busy; exp_start = -1;
        #2;
        rst_n = 1'b1;
        exp_start = cyc + period + 3;
        chk("rst_mid_avg", avg, 32'd0);
        chk("rst_mid_measStart", measStart, 32'd0);
        wait_av();
        chk("avg_50", avg, 32'd50);

        // Back-to-back single-sample averaging on the second instance.
        pulses = 0; last0 = 0;
        @(posedge lfClk); #2;
        enable0 = 1'b1;
        for (int k = 0; k < 60 && pulses < 3; k++) begin
            @(posedge lfClk); #2;
            if (avgValid0) begin
                pulses++;
                chk("avg0_1023", avg0, 32'd1023);
                if (pulses > 1) chk("avgValid0_gap_7", cyc - last0, 32'd7);
                last0 = cyc;
            end
        end
        chk("avgValid0_pulses", pulses, 32'd3);
        chk("alarm0_set", alarm0, 32'd1);

        repeat (5) @(posedge lfClk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
